// File: rtl/matrix_stream_loader.sv
// Streams a packed flat matrix to the matrix memory one element per accepted beat,
// in row- or column-major order, with backpressure, abort and a done pulse.
module matrix_stream_loader #(
  parameter int unsigned DW    = 32,
  parameter int unsigned MAX_M = 128,
  parameter int unsigned MAX_N = 128
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              start,
  input  logic                                              abort,
  input  logic                                              col_major,
  input  logic [((MAX_M > 1) ? $clog2(MAX_M) : 1):0]        m_dim,
  input  logic [((MAX_N > 1) ? $clog2(MAX_N) : 1):0]        n_dim,
  input  logic [MAX_M*MAX_N*DW-1:0]                         matrix_in,
  input  logic                                              wr_ready,
  output logic                                              wr_valid,
  output logic [((MAX_M > 1) ? $clog2(MAX_M) : 1)-1:0]      m_addr,
  output logic [((MAX_N > 1) ? $clog2(MAX_N) : 1)-1:0]      n_addr,
  output logic [DW-1:0]                                     wr_data,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              dim_err
);

  localparam int unsigned AW = (MAX_M > 1) ? $clog2(MAX_M) : 1;
  localparam int unsigned BW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int unsigned KW = (MAX_M * MAX_N > 1) ? $clog2(MAX_M * MAX_N) : 1;
  localparam int unsigned IW = (MAX_M * MAX_N * DW > 1) ? $clog2(MAX_M * MAX_N * DW) : 1;

  typedef enum logic {IDLE, LOAD} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   m_q, m_d, m_last_q, m_last_d;
  logic [BW-1:0]   n_q, n_d, n_last_q, n_last_d;
  logic [KW-1:0]   k_q, k_d;
  logic [BW:0]     stride_q, stride_d;
  logic            col_q, col_d;
  logic            wr_valid_q, wr_valid_d;
  logic [DW-1:0]   data_q, data_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            fire, last;
  logic [IW-1:0]   bit_idx;

  // Registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      m_q        <= '0;
      n_q        <= '0;
      m_last_q   <= '0;
      n_last_q   <= '0;
      k_q        <= '0;
      stride_q   <= '0;
      col_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      n_q        <= n_d;
      m_last_q   <= m_last_d;
      n_last_q   <= n_last_d;
      k_q        <= k_d;
      stride_q   <= stride_d;
      col_q      <= col_d;
      wr_valid_q <= wr_valid_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next state; k tracks the dense source index m*n_dim+n incrementally
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    n_d        = n_q;
    m_last_d   = m_last_q;
    n_last_d   = n_last_q;
    k_d        = k_q;
    stride_d   = stride_q;
    col_d      = col_q;
    wr_valid_d = wr_valid_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fire       = wr_valid_q & wr_ready;
    last       = (m_q == m_last_q) && (n_q == n_last_q);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ((m_dim > (AW+1)'(MAX_M)) || (n_dim > (BW+1)'(MAX_N))) begin
            err_d = 1'b1;
          end else if ((m_dim == '0) || (n_dim == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d    = LOAD;
            m_d        = '0;
            n_d        = '0;
            k_d        = '0;
            m_last_d   = AW'(m_dim - (AW+1)'(1));
            n_last_d   = BW'(n_dim - (BW+1)'(1));
            stride_d   = n_dim;
            col_d      = col_major;
            wr_valid_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (fire) begin
          if (last) begin
            state_d    = IDLE;
            wr_valid_d = 1'b0;
            done_d     = 1'b1;
            m_d        = '0;
            n_d        = '0;
            k_d        = '0;
          end else if (!col_q) begin
            k_d = k_q + KW'(1);
            if (n_q == n_last_q) begin
              n_d = '0;
              m_d = m_q + AW'(1);
            end else begin
              n_d = n_q + BW'(1);
            end
          end else begin
            if (m_q == m_last_q) begin
              m_d = '0;
              n_d = n_q + BW'(1);
              k_d = KW'(n_q) + KW'(1);
            end else begin
              m_d = m_q + AW'(1);
              k_d = k_q + KW'(stride_q);
            end
          end
        end
        // Abort lets a same-cycle transfer complete but suppresses done
        if (abort) begin
          state_d    = IDLE;
          wr_valid_d = 1'b0;
          done_d     = 1'b0;
          m_d        = '0;
          n_d        = '0;
          k_d        = '0;
        end
      end
    endcase

    bit_idx = IW'(k_d) * IW'(DW);
    data_d  = (state_d == LOAD) ? matrix_in[bit_idx +: DW] : '0;
  end

  assign wr_valid = wr_valid_q;
  assign m_addr   = m_q;
  assign n_addr   = n_q;
  assign wr_data  = data_q;
  assign busy     = (state_q == LOAD);
  assign done     = done_q;
  assign dim_err  = err_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Scoreboard bench for matrix_stream_loader on a reduced 4x5, 8-bit configuration.
module tb_matrix_stream_loader;

  localparam int unsigned DW    = 8;
  localparam int unsigned MAX_M = 4;
  localparam int unsigned MAX_N = 5;
  localparam int unsigned AW    = 2;
  localparam int unsigned BW    = 3;
  localparam int unsigned TOT   = MAX_M * MAX_N;

  typedef struct packed {
    logic [AW-1:0] m;
    logic [BW-1:0] n;
    logic [DW-1:0] d;
  } beat_t;

  logic               clk = 1'b0;
  logic               reset, start, abort, col_major, wr_ready;
  logic [AW:0]        m_dim;
  logic [BW:0]        n_dim;
  logic [TOT*DW-1:0]  matrix_in;
  logic               wr_valid, busy, done, dim_err;
  logic [AW-1:0]      m_addr;
  logic [BW-1:0]      n_addr;
  logic [DW-1:0]      wr_data;

  beat_t exp_q[$];
  beat_t mon_e, stall_beat;
  logic  stall_prev = 1'b0;
  int total = 0, bad = 0;
  int cyc = 0, fire_cnt = 0, valid_cnt = 0, done_cnt = 0, err_cnt = 0;
  int last_fire_cyc = 0, done_cyc = 0;

  matrix_stream_loader #(.DW(DW), .MAX_M(MAX_M), .MAX_N(MAX_N)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .col_major(col_major),
    .m_dim(m_dim), .n_dim(n_dim), .matrix_in(matrix_in), .wr_ready(wr_ready),
    .wr_valid(wr_valid), .m_addr(m_addr), .n_addr(n_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .dim_err(dim_err)
  );

  always #5 clk = ~clk;

  // Monitor: scoreboard pops on each transfer, hold check after each stall
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (wr_valid) valid_cnt++;
      if (stall_prev && wr_valid) begin
        total++;
        if ({m_addr, n_addr, wr_data} !== stall_beat) begin
          bad++;
          $display("FAIL hold: got (%0d,%0d)=%0d want (%0d,%0d)=%0d", m_addr, n_addr, wr_data,
                   stall_beat.m, stall_beat.n, stall_beat.d);
        end
      end
      stall_prev = wr_valid && !wr_ready;
      stall_beat = {m_addr, n_addr, wr_data};
      if (wr_valid && wr_ready) begin
        fire_cnt++;
        last_fire_cyc = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat: unexpected (%0d,%0d)=%0d", m_addr, n_addr, wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          if ({m_addr, n_addr, wr_data} !== mon_e) begin
            bad++;
            $display("FAIL beat: got (%0d,%0d)=%0d want (%0d,%0d)=%0d", m_addr, n_addr, wr_data,
                     mon_e.m, mon_e.n, mon_e.d);
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (dim_err) err_cnt++;
    end
  end

  task automatic fill(input int base);
    for (int k = 0; k < int'(TOT); k++) matrix_in[k*DW +: DW] = DW'(base + k);
  endtask

  task automatic push_exp(input int m, input int n, input bit col, input int base);
    beat_t b;
    for (int o = 0; o < (col ? n : m); o++) begin
      for (int i = 0; i < (col ? m : n); i++) begin
        b.m = AW'(col ? i : o);
        b.n = BW'(col ? o : i);
        b.d = DW'(base + int'(b.m) * n + int'(b.n));
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready high, 1: random ready, 2: stall (1,1) twice, 3: start pulse mid-load
  task automatic run_load(input string name, input int m, input int n, input bit col,
                          input int mode, input int base);
    int f0, d0, t, c11, stalls;
    f0 = fire_cnt; d0 = done_cnt; t = 0; c11 = 0; stalls = 0;
    fill(base);
    push_exp(m, n, col, base);
    start = 1'b1; m_dim = (AW+1)'(m); n_dim = (BW+1)'(n); col_major = col; wr_ready = 1'b1;
    tick();
    start = 1'b0;
    while (done_cnt == d0 && t < 2000) begin
      case (mode)
        1: wr_ready = 1'($urandom_range(0, 1));
        2: begin
          if (wr_valid && m_addr == 1 && n_addr == 1) begin
            c11++;
            if (stalls < 2) begin wr_ready = 1'b0; stalls++; end
            else wr_ready = 1'b1;
          end else wr_ready = 1'b1;
        end
        3: begin
          start = (t == 3);
          if (t == 3) begin m_dim = 1; n_dim = 1; col_major = ~col; end
          wr_ready = 1'b1;
        end
        default: wr_ready = 1'b1;
      endcase
      tick();
      t++;
    end
    start = 1'b0;
    total++;
    if (done_cnt == d0) begin
      bad++;
      $display("FAIL %s done_timeout: beats=%0d want %0d", name, fire_cnt - f0, m * n);
    end
    total++;
    if (fire_cnt - f0 !== m * n) begin
      bad++;
      $display("FAIL %s beat_count: got %0d want %0d", name, fire_cnt - f0, m * n);
    end
    total++;
    if (done_cyc !== last_fire_cyc + 1) begin
      bad++;
      $display("FAIL %s done_latency: got %0d want %0d", name, done_cyc - last_fire_cyc, 1);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s missing_beats: got %0d left want 0", name, exp_q.size());
      exp_q.delete();
    end
    if (mode == 2) begin
      total++;
      if (c11 !== 3) begin
        bad++;
        $display("FAIL %s stall_hold_cycles: got %0d want 3", name, c11);
      end
    end
    tick();
    tick();
    total++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0 || wr_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s end_state: dones=%0d busy=%b valid=%b want 1 0 0", name,
               done_cnt - d0, busy, wr_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; col_major = 1'b0; wr_ready = 1'b1;
    m_dim = '0; n_dim = '0; matrix_in = '0;
    tick();
    total++;
    if ({wr_valid, m_addr, n_addr, wr_data, busy, done, dim_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b m=%0d n=%0d d=%0d b=%b dn=%b e=%b want all 0",
               wr_valid, m_addr, n_addr, wr_data, busy, done, dim_err);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_bad_dims(input string name, input int m, input int n, input bit want_err);
    int v0, d0, e0;
    v0 = valid_cnt; d0 = done_cnt; e0 = err_cnt;
    start = 1'b1; m_dim = (AW+1)'(m); n_dim = (BW+1)'(n);
    tick();
    start = 1'b0;
    repeat (3) tick();
    total++;
    if (valid_cnt != v0 || done_cnt - d0 !== (want_err ? 0 : 1) || err_cnt - e0 !== (want_err ? 1 : 0)) begin
      bad++;
      $display("FAIL %s: valids=%0d dones=%0d errs=%0d want 0 %0d %0d", name, valid_cnt - v0,
               done_cnt - d0, err_cnt - e0, want_err ? 0 : 1, want_err ? 1 : 0);
    end
  endtask

  task automatic test_back_to_back();
    int f0, d0, t;
    f0 = fire_cnt; d0 = done_cnt; t = 0;
    fill(0);
    push_exp(1, 2, 0, 0);
    push_exp(2, 2, 0, 0);
    start = 1'b1; m_dim = 1; n_dim = 2; col_major = 1'b0; wr_ready = 1'b1;
    tick();
    start = 1'b0;
    while (!done && t < 50) begin tick(); t++; end
    start = 1'b1; m_dim = 2; n_dim = 2;
    tick();
    start = 1'b0;
    total++;
    if (wr_valid !== 1'b1 || busy !== 1'b1 || m_addr !== 0 || n_addr !== 0) begin
      bad++;
      $display("FAIL b2b_restart: got v=%b b=%b (%0d,%0d) want 1 1 (0,0)", wr_valid, busy, m_addr, n_addr);
    end
    t = 0;
    while (done_cnt - d0 < 2 && t < 50) begin tick(); t++; end
    total++;
    if (fire_cnt - f0 !== 6 || done_cnt - d0 !== 2 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_totals: beats=%0d dones=%0d left=%0d want 6 2 0", fire_cnt - f0,
               done_cnt - d0, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_abort();
    int f0, d0, t;
    f0 = fire_cnt; d0 = done_cnt; t = 0;
    fill(0);
    push_exp(1, 4, 0, 0);
    start = 1'b1; m_dim = 4; n_dim = 4; col_major = 1'b0; wr_ready = 1'b1;
    tick();
    start = 1'b0;
    while (fire_cnt - f0 < 4 && t < 50) begin tick(); t++; end
    abort = 1'b1; wr_ready = 1'b0;
    tick();
    abort = 1'b0;
    total++;
    if (wr_valid !== 1'b0 || busy !== 1'b0 || m_addr !== 0 || n_addr !== 0) begin
      bad++;
      $display("FAIL abort_state: got v=%b b=%b (%0d,%0d) want 0 0 (0,0)", wr_valid, busy, m_addr, n_addr);
    end
    wr_ready = 1'b1;
    repeat (3) tick();
    total++;
    if (fire_cnt - f0 !== 4 || done_cnt != d0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL abort_counts: beats=%0d dones=%0d left=%0d want 4 0 0", fire_cnt - f0,
               done_cnt - d0, exp_q.size());
      exp_q.delete();
    end
    run_load("after_abort_1x1", 1, 1, 0, 0, 77);
  endtask

  task automatic test_reset_mid_load();
    int d0;
    fill(3);
    push_exp(4, 5, 0, 3);
    start = 1'b1; m_dim = 4; n_dim = 5; col_major = 1'b0; wr_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) begin wr_ready = 1'($urandom_range(0, 1)); tick(); end
    d0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({wr_valid, m_addr, n_addr, wr_data, busy, done, dim_err} !== '0) begin
      bad++;
      $display("FAIL reset_mid_load: got v=%b m=%0d n=%0d d=%0d b=%b dn=%b e=%b want all 0",
               wr_valid, m_addr, n_addr, wr_data, busy, done, dim_err);
    end
    exp_q.delete();
    tick();
    reset = 1'b0;
    repeat (4) tick();
    total++;
    if (done_cnt != d0 || wr_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_done: dones=%0d v=%b b=%b want 0 0 0", done_cnt - d0, wr_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    run_load("row_2x3", 2, 3, 0, 0, 10);
    run_load("col_2x3", 2, 3, 1, 0, 10);
    run_load("stall_3x3", 3, 3, 0, 2, 40);
    test_bad_dims("zero_m", 0, 3, 1'b0);
    test_bad_dims("zero_n", 2, 0, 1'b0);
    test_bad_dims("over_m", MAX_M + 1, 3, 1'b1);
    test_bad_dims("over_n", 2, MAX_N + 1, 1'b1);
    run_load("start_in_load_3x3", 3, 3, 0, 3, 20);
    test_back_to_back();
    test_abort();
    run_load("full_row_random", MAX_M, MAX_N, 0, 1, 100);
    run_load("full_col_random", MAX_M, MAX_N, 1, 1, 60);
    test_reset_mid_load();
    run_load("post_reset_2x2", 2, 2, 1, 0, 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
